// File: rtl/pipe_pkg.sv
// Shared types for the pipeline stage registers: fetch payload layout,
// its width, and the occupancy encoding of a skid-buffered stage.
package pipe_pkg;

  localparam int unsigned FETCH_PAYLOAD_W = 129;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        pred_taken;
    logic [31:0] pred_pc;
  } fetch_payload_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } stage_state_e;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating event counter: counts cycles with inc high, sticks at all-ones,
// synchronous clear.
module pipe_sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Count up until saturation; clear has priority.
  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage register with a main slot and a one-entry skid
// slot so in_ready can be registered without losing throughput. Flush kills
// all held entries. Optional perf counters (stall/flush) are built when
// PIPE_STAGE_PERF_EN is defined.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int unsigned       DATA_W     = FETCH_PAYLOAD_W,
  parameter logic [DATA_W-1:0] RESET_DATA = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
`endif
);

  stage_state_e      state;
  logic              main_v;
  logic              skid_v;
  logic [DATA_W-1:0] main_d;
  logic [DATA_W-1:0] skid_d;
  logic              in_xfer;
  logic              out_xfer;

  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = main_v & out_ready;
  assign out_valid = main_v;
  assign out_data  = main_d;

  // Occupancy FSM: reset and flush empty the stage; otherwise move entries
  // main <- in / skid, keeping the skid entry older than any new input.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state    <= EMPTY;
      main_v   <= 1'b0;
      skid_v   <= 1'b0;
      main_d   <= RESET_DATA;
      skid_d   <= RESET_DATA;
      in_ready <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (in_xfer) begin
            main_d <= in_data;
            main_v <= 1'b1;
            state  <= HALF;
          end
        end
        HALF: begin
          if (out_xfer && in_xfer) begin
            main_d <= in_data;
          end else if (out_xfer) begin
            main_v <= 1'b0;
            state  <= EMPTY;
          end else if (in_xfer) begin
            skid_d   <= in_data;
            skid_v   <= 1'b1;
            in_ready <= 1'b0;
            state    <= FULL;
          end
        end
        FULL: begin
          if (out_xfer) begin
            main_d   <= skid_d;
            skid_v   <= 1'b0;
            in_ready <= 1'b1;
            state    <= HALF;
          end
        end
        default: begin
          state    <= EMPTY;
          main_v   <= 1'b0;
          skid_v   <= 1'b0;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic stall_inc;
  logic flush_inc;

  assign stall_inc = main_v & ~out_ready;
  assign flush_inc = flush & (main_v | skid_v);

  pipe_sat_counter #(.WIDTH(32)) u_stall_cnt (
    .clk   (clk),
    .clr   (rst),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  pipe_sat_counter #(.WIDTH(32)) u_flush_cnt (
    .clk   (clk),
    .clr   (rst),
    .inc   (flush_inc),
    .count (flush_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: reset, streaming, backpressure, flush,
// reset/flush collision and (with PIPE_STAGE_PERF_EN) perf counters.
module tb_pipe_stage_skid;

  localparam int unsigned W = 129;

  logic         clk;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0]  stall_cnt;
  logic [31:0]  flush_cnt;
`endif

  int checks;
  int failures;

  pipe_stage_skid #(.DATA_W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [W-1:0] got,
                           input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b1;
    in_data   = W'(8'hAA);
    out_ready = 1'b0;

    // 1. Reset held two cycles with input offered
    step();
    step();
    check_val("rst_out_valid", W'(out_valid), W'(0));
    check_val("rst_out_data", out_data, W'(0));
    check_val("rst_in_ready", W'(in_ready), W'(1));
    rst      = 1'b0;
    in_valid = 1'b0;
    step();
    check_val("post_rst_in_ready", W'(in_ready), W'(1));
    check_val("post_rst_out_valid", W'(out_valid), W'(0));

    // 2. Streaming 1..4 with out_ready high
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_data = W'(i);
      step();
      check_val("stream_valid", W'(out_valid), W'(1));
      check_val("stream_data", out_data, W'(i));
      check_val("stream_in_ready", W'(in_ready), W'(1));
    end
    in_valid = 1'b0;
    step();
    check_val("stream_drain", W'(out_valid), W'(0));

    // 3. Backpressure: A then B while stalled
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = W'(8'hA0);
    step();
    check_val("bp_a_valid", W'(out_valid), W'(1));
    check_val("bp_a_data", out_data, W'(8'hA0));
    check_val("bp_half_ready", W'(in_ready), W'(1));
    in_data = W'(8'hB0);
    step();
    check_val("bp_full_ready", W'(in_ready), W'(0));
    check_val("bp_full_data", out_data, W'(8'hA0));
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("bp_stall_data", out_data, W'(8'hA0));
      check_val("bp_stall_ready", W'(in_ready), W'(0));
    end
    out_ready = 1'b1;
    step();
    check_val("bp_b_valid", W'(out_valid), W'(1));
    check_val("bp_b_data", out_data, W'(8'hB0));
    check_val("bp_b_ready", W'(in_ready), W'(1));
    step();
    check_val("bp_empty", W'(out_valid), W'(0));

    // 4. Flush while FULL with C offered
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = W'(8'h11);
    step();
    in_data = W'(8'h22);
    step();
    check_val("fl_full_ready", W'(in_ready), W'(0));
    flush   = 1'b1;
    in_data = W'(8'hCC);
    step();
    check_val("fl_valid", W'(out_valid), W'(0));
    check_val("fl_ready", W'(in_ready), W'(1));
    check_val("fl_data", out_data, W'(0));
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    check_val("fl_no_c", W'(out_valid), W'(0));

    // 4b. Flush while HALF drops offered input even with in_ready high
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = W'(8'h44);
    step();
    flush   = 1'b1;
    in_data = W'(8'hC1);
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    step();
    check_val("fl_half_valid", W'(out_valid), W'(0));
    check_val("fl_half_data", out_data, W'(0));

    // 5. Reset and flush together with data held, then D
    in_valid = 1'b1;
    in_data  = W'(8'h33);
    step();
    check_val("col_held", out_data, W'(8'h33));
    rst   = 1'b1;
    flush = 1'b1;
    step();
    check_val("col_valid", W'(out_valid), W'(0));
    check_val("col_data", out_data, W'(0));
    check_val("col_ready", W'(in_ready), W'(1));
    rst     = 1'b0;
    flush   = 1'b0;
    in_data = W'(8'hDD);
    step();
    check_val("col_d_valid", W'(out_valid), W'(1));
    check_val("col_d_data", out_data, W'(8'hDD));
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    check_val("col_d_drain", W'(out_valid), W'(0));

`ifdef PIPE_STAGE_PERF_EN
    // 6. Perf counters: 5 stalls, 1 flush with data, 1 flush when empty
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_val("perf_stall_clr", W'(stall_cnt), W'(0));
    check_val("perf_flush_clr", W'(flush_cnt), W'(0));
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = W'(8'h55);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    out_ready = 1'b1;
    flush     = 1'b1;
    step();
    step();
    flush = 1'b0;
    step();
    check_val("perf_stall", W'(stall_cnt), W'(5));
    check_val("perf_flush", W'(flush_cnt), W'(1));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
Generic parametrised pipeline stage register that replaces the fixed-field stall-only pipeline registers with a valid/ready handshake.
- Holds a main slot plus a one-entry skid slot, so `in_ready` is registered and full throughput is kept under backpressure.
- Adds flush/kill for branch-mispredict recovery and explicit bubble tracking via a valid bit.
- First instance sits between fetch and decode; later instances cover ID/EX, EX/MEM and MEM/WB.

Parameters:
DATA_W, 129, payload width in bits (default = fetch payload: instr, pc, pc_plus4, pred_taken, pred_pc).
RESET_DATA, '0, value loaded into both data slots on reset and flush.

Ports:
clk  in  1  clock, all state updates on posedge.
rst  in  1  reset, synchronous, active-high.
flush  in  1  kill all held entries this cycle.
in_valid  in  1  upstream entry valid.
in_data  in  DATA_W  upstream payload.
in_ready  out  1  stage can accept this cycle (registered).
out_valid  out  1  downstream entry valid.
out_data  out  DATA_W  downstream payload.
out_ready  in  1  downstream accepts this cycle (low = stall).

Behaviour:
- Internal state: `main_v`/`main_d`, `skid_v`/`skid_d`. Encoded states are EMPTY (neither valid), HALF (main only) and FULL (main and skid).
- Outputs:
  - `out_valid` = `main_v`; `out_data` = `main_d`.
  - `in_ready` = registered (next state != FULL).
- Reset (`rst`=1 at posedge):
  - `main_v`=0, `skid_v`=0, both data regs = RESET_DATA.
  - `in_ready` = 1 from the first cycle after reset; `out_valid`=0.
  - A reset mid-operation discards both entries.
- Transfers:
  - Input transfer = `in_valid` & `in_ready`.
  - Output transfer = `out_valid` & `out_ready`.
- Latency: 1 cycle from input transfer to `out_valid` when EMPTY. Sustained throughput is 1/cycle with `out_ready` held high.
- Transitions (no flush):
  - EMPTY: in xfer -> main<=in, HALF; else stay.
  - HALF, out xfer & in xfer -> main<=in, HALF.
  - HALF, out xfer only -> EMPTY.
  - HALF, in xfer only -> skid<=in, FULL (`in_ready` drops next cycle).
  - HALF, neither -> hold.
  - FULL (`in_ready`=0): out xfer -> main<=skid, `skid_v`=0, HALF; else hold.
- Stability: while `out_valid` & !`out_ready`, `out_data` holds bit-for-bit.
- Flush:
  - Highest priority below `rst`: next state EMPTY, both data regs = RESET_DATA, `in_ready`=1 next cycle.
  - `in_data` presented in the flush cycle is dropped, even if `in_valid`=1.
  - A simultaneous output transfer in the flush cycle still counts as consumed downstream; the stage does not retract it.
- Ordering: strict FIFO; skid is always older than any new input.
- Invariant: `skid_v`=1 implies `main_v`=1.
- The data path carries no arithmetic; the payload is opaque.

Optional Feature:
Macro PIPE_STAGE_PERF_EN.
- With macro: two extra outputs, both 32-bit, saturating at 32'hFFFF_FFFF, cleared by `rst` only (not by `flush`).
  - `stall_cnt` increments each cycle `out_valid` & !`out_ready`.
  - `flush_cnt` increments each cycle `flush` & (`main_v` | `skid_v`).
- Without macro: the ports and counters do not exist; handshake behaviour is identical.

Decomposition:
- Package `pipe_pkg`:
  - `typedef fetch_payload_t` (packed struct: instr[31:0], pc[31:0], pc_plus4[31:0], pred_taken, pred_pc[31:0]).
  - `localparam FETCH_PAYLOAD_W` = 129.
  - `stage_state_e` enum {EMPTY, HALF, FULL}.
- Sub-module `pipe_sat_counter` (WIDTH param, `inc`, `clr`) implements both perf counters; it is instantiated only under PIPE_STAGE_PERF_EN.

Test Plan:
1. Reset: hold `rst`=1 two cycles with `in_valid`=1, `in_data`=0xAA -> `out_valid`=0, `out_data`=0, and `in_ready`=1 on the first post-reset cycle.
2. Streaming: `out_ready`=1, inputs 1,2,3,4 back-to-back -> outputs 1,2,3,4 on consecutive cycles, each one cycle late; `in_ready` never drops.
3. Backpressure: send A then B while `out_ready`=0 -> FULL and `in_ready`=0. Assert `out_ready` -> A then B delivered, no loss or duplication; `out_data`=A stays stable throughout the stall.
4. Flush in FULL with `in_valid`=1, `in_data`=C -> next cycle `out_valid`=0 and `in_ready`=1; C never appears at the output.
5. Flush and reset collide: `rst` and `flush` both high with data held -> reset values result; a subsequent input D emerges after 1 cycle.
6. PIPE_STAGE_PERF_EN: 5 stall cycles plus 1 flush with data held, then 1 flush when EMPTY -> `stall_cnt`=5, `flush_cnt`=1.
